// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer: single-master command sequencer for a 32x32 register file.
// Each accepted command reads two registers, computes ADD/SUB/AND or performs
// a SWAP, writes the result back, then reports it with a one-cycle valid pulse.
// Every output apart from o_cmd_ready is registered, so each value on the
// register-file interface appears exactly in the cycle of its FSM state.
module rf_op_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [ADDR_W-1:0] i_cmd_rs,
    input  logic [ADDR_W-1:0] i_cmd_rt,
    input  logic [ADDR_W-1:0] i_cmd_rd,
    output logic [ADDR_W-1:0] o_rf_add_a,
    output logic [ADDR_W-1:0] o_rf_add_b,
    output logic [ADDR_W-1:0] o_rf_add_c,
    output logic [DATA_W-1:0] o_rf_din_c,
    output logic              o_rf_we,
    input  logic [DATA_W-1:0] i_rf_dout_a,
    input  logic [DATA_W-1:0] i_rf_dout_b,
    output logic              o_res_valid,
    output logic [DATA_W-1:0] o_res_data,
    output logic              o_res_ovf
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCap,
        StWr1,
        StWr2,
        StDone
    } state_e;

    state_e r_state;
    state_e w_state_next;

    // Latched command
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_rs;
    logic [ADDR_W-1:0] r_rt;
    logic [ADDR_W-1:0] r_rd;

    // Captured operand A and computed result
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_result;
    logic              r_ovf;

    // Registered output copies
    logic [ADDR_W-1:0] r_rf_add_a;
    logic [ADDR_W-1:0] r_rf_add_b;
    logic [ADDR_W-1:0] r_rf_add_c;
    logic [DATA_W-1:0] r_rf_din_c;
    logic              r_rf_we;
    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_data;
    logic              r_res_ovf;

    // Next-state values produced by the combinational process
    logic              w_cmd_load;
    logic              w_cap;
    logic [ADDR_W-1:0] w_rf_add_a_next;
    logic [ADDR_W-1:0] w_rf_add_b_next;
    logic [ADDR_W-1:0] w_rf_add_c_next;
    logic [DATA_W-1:0] w_rf_din_c_next;
    logic              w_rf_we_next;
    logic              w_res_valid_next;
    logic [DATA_W-1:0] w_res_data_next;
    logic              w_res_ovf_next;

    // ALU on the live read data; only meaningful in StCap
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic [DATA_W-1:0] w_and;
    logic [DATA_W-1:0] w_alu;
    logic              w_ovf;
    logic              w_sign_a;
    logic              w_sign_b;

    // Compute ALU result and signed overflow from the register-file read data
    always_comb begin
        w_sum    = i_rf_dout_a + i_rf_dout_b;
        w_diff   = i_rf_dout_a - i_rf_dout_b;
        w_and    = i_rf_dout_a & i_rf_dout_b;
        w_sign_a = i_rf_dout_a[DATA_W-1];
        w_sign_b = i_rf_dout_b[DATA_W-1];
        w_alu    = '0;
        w_ovf    = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_alu = w_sum;
                w_ovf = (w_sign_a == w_sign_b) && (w_sum[DATA_W-1] != w_sign_a);
            end
            OP_SUB: begin
                w_alu = w_diff;
                w_ovf = (w_sign_a != w_sign_b) && (w_diff[DATA_W-1] != w_sign_a);
            end
            OP_AND: begin
                w_alu = w_and;
            end
            default: begin
                w_alu = '0;
            end
        endcase
    end

    // Next-state and next-output decode; holds are the default
    always_comb begin
        w_state_next     = r_state;
        w_cmd_load       = 1'b0;
        w_cap            = 1'b0;
        w_rf_add_a_next  = r_rf_add_a;
        w_rf_add_b_next  = r_rf_add_b;
        w_rf_add_c_next  = r_rf_add_c;
        w_rf_din_c_next  = r_rf_din_c;
        w_rf_we_next     = 1'b0;
        w_res_valid_next = 1'b0;
        w_res_data_next  = r_res_data;
        w_res_ovf_next   = r_res_ovf;
        case (r_state)
            StIdle: begin
                if (i_cmd_valid) begin
                    w_cmd_load      = 1'b1;
                    w_rf_add_a_next = i_cmd_rs;
                    w_rf_add_b_next = i_cmd_rt;
                    w_state_next    = StRd;
                end
            end
            StRd: begin
                w_state_next = StCap;
            end
            StCap: begin
                // Read data is valid now; set up the first write for StWr1
                w_cap = 1'b1;
                if (r_op == OP_SWAP) begin
                    w_rf_add_c_next = r_rs;
                    w_rf_din_c_next = i_rf_dout_b;
                    w_rf_we_next    = (r_rs != '0);
                end else begin
                    w_rf_add_c_next = r_rd;
                    w_rf_din_c_next = w_alu;
                    w_rf_we_next    = (r_rd != '0);
                end
                w_state_next = StWr1;
            end
            StWr1: begin
                if (r_op == OP_SWAP) begin
                    w_rf_add_c_next = r_rt;
                    w_rf_din_c_next = r_op_a;
                    w_rf_we_next    = (r_rt != '0);
                    w_state_next    = StWr2;
                end else begin
                    w_res_valid_next = 1'b1;
                    w_res_data_next  = r_result;
                    w_res_ovf_next   = r_ovf;
                    w_state_next     = StDone;
                end
            end
            StWr2: begin
                w_res_valid_next = 1'b1;
                w_res_data_next  = r_op_a;
                w_res_ovf_next   = 1'b0;
                w_state_next     = StDone;
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Command, operand and output registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_op        <= OP_ADD;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_op_a      <= '0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
            r_rf_add_a  <= '0;
            r_rf_add_b  <= '0;
            r_rf_add_c  <= '0;
            r_rf_din_c  <= '0;
            r_rf_we     <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_ovf   <= 1'b0;
        end else begin
            if (w_cmd_load) begin
                r_op <= i_cmd_op;
                r_rs <= i_cmd_rs;
                r_rt <= i_cmd_rt;
                r_rd <= i_cmd_rd;
            end
            if (w_cap) begin
                r_op_a   <= i_rf_dout_a;
                r_result <= w_alu;
                r_ovf    <= w_ovf;
            end
            r_rf_add_a  <= w_rf_add_a_next;
            r_rf_add_b  <= w_rf_add_b_next;
            r_rf_add_c  <= w_rf_add_c_next;
            r_rf_din_c  <= w_rf_din_c_next;
            r_rf_we     <= w_rf_we_next;
            r_res_valid <= w_res_valid_next;
            r_res_data  <= w_res_data_next;
            r_res_ovf   <= w_res_ovf_next;
        end
    end

    // Output mapping
    always_comb begin
        o_cmd_ready = (r_state == StIdle);
        o_rf_add_a  = r_rf_add_a;
        o_rf_add_b  = r_rf_add_b;
        o_rf_add_c  = r_rf_add_c;
        o_rf_din_c  = r_rf_din_c;
        o_rf_we     = r_rf_we;
        o_res_valid = r_res_valid;
        o_res_data  = r_res_data;
        o_res_ovf   = r_res_ovf;
    end

endmodule
